bcd_timer_ctrl: RTL and testbench

- Sequencing controller for a four-digit MM:SS timer built from four external single-digit BCD counters (sec0, sec1, min0, min1).
- Generates the count tick, the per-digit increase/decrease carry/borrow strobes, the count enable, the synchronous clear, the mode select and the terminal flags.
- Runs a start/pause/clear/mode FSM driven by debounced one-cycle button pulses.
- Sits between the button debouncers and the digit counters. Its outputs drive the counter control inputs directly.

---
 rtl/timer_pkg.sv | 42 ++++
 rtl/bcd_timer_ctrl_if.sv | 29 ++
 rtl/tick_prescaler.sv | 46 ++++
 rtl/bcd_timer_ctrl.sv | 126 ++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared encodings and digit constants for the MM:SS BCD timer slice.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic DOWN_COUNT = 1'b0;
    localparam logic UP_COUNT   = 1'b1;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGITS_W   = DIGIT_W * NUM_DIGITS;

    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC0_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC1_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] MIN0_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] MIN1_MAX = 4'd5;

    typedef struct packed {
        logic [DIGIT_W-1:0] min1;
        logic [DIGIT_W-1:0] min0;
        logic [DIGIT_W-1:0] sec1;
        logic [DIGIT_W-1:0] sec0;
    } digits_t;

    // Per-digit upper limit; up counters wrap to zero, down counters wrap to the limit.
    localparam digits_t DIGIT_LIMIT = digits_t'({MIN1_MAX, MIN0_MAX, SEC1_MAX, SEC0_MAX});
    localparam digits_t UP_WRAP     = digits_t'(DIGITS_W'(0));
    localparam digits_t DOWN_WRAP   = DIGIT_LIMIT;
    localparam digits_t UP_INIT     = digits_t'(DIGITS_W'(0));
    localparam digits_t DOWN_INIT   = DIGIT_LIMIT;

    function automatic digits_t init_digits(input logic mode_sel);
        return (mode_sel == UP_COUNT) ? UP_INIT : DOWN_INIT;
    endfunction

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Button, digit feedback and counter-control bundle between the debouncers/counters and the controller.
interface bcd_timer_ctrl_if;
    import timer_pkg::*;

    logic          start_pause;
    logic          clear;
    logic          mode;
    digits_t       digits;
    logic          mode_select;
    logic          en;
    logic          rst;
    logic [3:0]    increase;
    logic [3:0]    decrease;
    logic          zero;
    logic          top;
    logic          done;
    logic [1:0]    state;

    modport master (
        output start_pause, clear, mode, digits,
        input  mode_select, en, rst, increase, decrease, zero, top, done, state
    );

    modport slave (
        input  start_pause, clear, mode, digits,
        output mode_select, en, rst, increase, decrease, zero, top, done, state
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle registered tick every TICK_DIV cycles of run time.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned PRESC_W  = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               tick_q, tick_d;

    // Clear wins over run; holding (neither) preserves the partial period across a pause.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Start/pause/clear/mode sequencer producing count enable, reload and carry/borrow strobes
// for four external BCD digit counters forming an MM:SS timer.
module bcd_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned PRESC_W  = 27
) (
    input  logic             clk,
    input  logic             reset,
    bcd_timer_ctrl_if.slave  bus
);

    state_e  state_q, state_d;
    logic    mode_q, mode_d;
    logic    rst_q, rst_d;
    logic    en_q, done_q;
    logic    tick;
    logic    zero_c, top_c, terminal_c, fire_c;
    logic [3:0] up_c, down_c;
    digits_t dig_c;

    assign dig_c = bus.digits;

    // Terminal flags come straight from counter feedback regardless of state.
    assign zero_c     = (dig_c == UP_INIT);
    assign top_c      = (dig_c == DIGIT_LIMIT);
    assign terminal_c = (mode_q == UP_COUNT) ? top_c : zero_c;

    // Next-state: clear dominates, then start_pause, then mode.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rst_d   = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            rst_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_pause) begin
                        state_d = ST_RUN;
                    end else if (bus.mode) begin
                        mode_d = ~mode_q;
                        rst_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.start_pause) begin
                        state_d = ST_PAUSE;
                    end else if (terminal_c) begin
                        state_d = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.start_pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (bus.mode) begin
                        mode_d  = ~mode_q;
                        rst_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= DOWN_COUNT;
            rst_q   <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rst_q   <= rst_d;
            en_q    <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PRESC_W  (PRESC_W)
    ) u_presc (
        .clk    (clk),
        .reset  (reset),
        .run_i  (state_q == ST_RUN),
        .clr_i  ((state_q == ST_IDLE) || (state_q == ST_DONE)),
        .tick_o (tick)
    );

    // Ripple carry/borrow chains; the terminal gate keeps the counters from wrapping past the end.
    assign fire_c = tick && (state_q == ST_RUN) && !terminal_c;

    assign up_c = {
        (dig_c.sec0 == SEC0_MAX) && (dig_c.sec1 == SEC1_MAX) && (dig_c.min0 == MIN0_MAX),
        (dig_c.sec0 == SEC0_MAX) && (dig_c.sec1 == SEC1_MAX),
        (dig_c.sec0 == SEC0_MAX),
        1'b1
    };

    assign down_c = {
        (dig_c.sec0 == 4'd0) && (dig_c.sec1 == 4'd0) && (dig_c.min0 == 4'd0),
        (dig_c.sec0 == 4'd0) && (dig_c.sec1 == 4'd0),
        (dig_c.sec0 == 4'd0),
        1'b1
    };

    assign bus.increase    = (fire_c && (mode_q == UP_COUNT))   ? up_c   : 4'b0000;
    assign bus.decrease    = (fire_c && (mode_q == DOWN_COUNT)) ? down_c : 4'b0000;
    assign bus.zero        = zero_c;
    assign bus.top         = top_c;
    assign bus.mode_select = mode_q;
    assign bus.en          = en_q;
    assign bus.rst         = rst_q;
    assign bus.done        = done_q;
    assign bus.state       = 2'(state_q);

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: directed plan then random buttons, against a seconds-based timer model.
module tb_bcd_timer_ctrl;

    localparam int TICK_DIV = 4;
    localparam int TOP_SEC  = 59 * 60 + 59;

    logic clk;
    logic reset;

    bcd_timer_ctrl_if bus ();

    bcd_timer_ctrl #(
        .TICK_DIV (TICK_DIV),
        .PRESC_W  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: timer value as whole seconds, plus controller status.
    int m_state;
    bit m_mode;
    bit m_tick;
    bit m_rst;
    int m_runcyc;
    int total;

    function automatic logic [15:0] to_bcd(input int t);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // A digit gets a strobe exactly when its value changes on the next step.
    function automatic logic [3:0] diff(input logic [15:0] a, input logic [15:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (a[4*i +: 4] != b[4*i +: 4]);
        return r;
    endfunction

    function automatic bit is_term();
        return m_mode ? (total == TOP_SEC) : (total == 0);
    endfunction

    task automatic exp_strobes(output logic [3:0] ei, output logic [3:0] ed);
        ei = 4'b0;
        ed = 4'b0;
        if (m_tick && m_state == 1 && !is_term()) begin
            if (m_mode) ei = diff(to_bcd(total), to_bcd(total + 1));
            else        ed = diff(to_bcd(total), to_bcd(total - 1));
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (t=%0t total=%0d)", tag, obs, exp, $time, total);
        end
    endtask

    task automatic check_all();
        logic [3:0] ei;
        logic [3:0] ed;
        exp_strobes(ei, ed);
        chk("state",       16'(bus.state),       16'(m_state));
        chk("mode_select", 16'(bus.mode_select), 16'(m_mode));
        chk("en",          16'(bus.en),          16'(m_state == 1));
        chk("rst",         16'(bus.rst),         16'(m_rst));
        chk("done",        16'(bus.done),        16'(m_state == 3));
        chk("increase",    16'(bus.increase),    16'(ei));
        chk("decrease",    16'(bus.decrease),    16'(ed));
        chk("zero",        16'(bus.zero),        16'(total == 0));
        chk("top",         16'(bus.top),         16'(total == TOP_SEC));
    endtask

    task automatic model_edge(input bit sp, input bit cl, input bit md);
        logic [3:0] ei;
        logic [3:0] ed;
        bit term;
        exp_strobes(ei, ed);
        term = is_term();
        // external digit counters
        if (m_rst)          total = m_mode ? 0 : TOP_SEC;
        else if (ei != 0)   total = total + 1;
        else if (ed != 0)   total = total - 1;
        // tick after every TICK_DIV-th cycle spent running since the last idle/done
        if (m_state == 1) begin
            m_runcyc++;
            m_tick = (m_runcyc % TICK_DIV) == 0;
        end else begin
            m_tick = 0;
            if (m_state != 2) m_runcyc = 0;
        end
        m_rst = 0;
        if (cl) begin
            m_state = 0;
            m_rst   = 1;
        end else if (m_state == 0) begin
            if (sp) m_state = 1;
            else if (md) begin m_mode = !m_mode; m_rst = 1; end
        end else if (m_state == 1) begin
            if (sp) m_state = 2;
            else if (term) m_state = 3;
        end else if (m_state == 2) begin
            if (sp) m_state = 1;
        end else begin
            if (md) begin m_mode = !m_mode; m_rst = 1; m_state = 0; end
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_mode   = 0;
        m_tick   = 0;
        m_rst    = 0;
        m_runcyc = 0;
    endtask

    task automatic cycle(input bit sp, input bit cl, input bit md);
        bus.start_pause = sp;
        bus.clear       = cl;
        bus.mode        = md;
        bus.digits      = to_bcd(total);
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge(sp, cl, md);
        #1;
        bus.start_pause = 1'b0;
        bus.clear       = 1'b0;
        bus.mode        = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int r;
        bit sp;
        bit cl;
        bit md;

        model_reset();
        total           = 2;
        reset           = 1'b0;
        bus.start_pause = 1'b0;
        bus.clear       = 1'b0;
        bus.mode        = 1'b0;
        bus.digits      = to_bcd(total);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b0);
        #1;

        // down count 00:02 to 00:00, then DONE
        cycle(1'b1, 1'b0, 1'b0);
        run(14);
        chk("done_after_zero", 16'(bus.done), 16'd1);

        // DONE + mode -> up mode; carries at 00:59 and 09:59; start at 59:59
        cycle(1'b0, 1'b0, 1'b1);
        run(2);
        total = 59;
        cycle(1'b1, 1'b0, 1'b0);
        run(5);
        cycle(1'b0, 1'b1, 1'b0);
        run(2);
        total = 9 * 60 + 59;
        cycle(1'b1, 1'b0, 1'b0);
        run(5);
        cycle(1'b0, 1'b1, 1'b0);
        run(2);
        total = TOP_SEC;
        cycle(1'b1, 1'b0, 1'b0);
        run(3);

        // back to down mode; borrow across all digits at 10:00
        cycle(1'b0, 1'b0, 1'b1);
        run(2);
        total = 600;
        cycle(1'b1, 1'b0, 1'b0);
        run(5);

        // pause with prescaler at 2, resume, tick one cycle later
        cycle(1'b0, 1'b1, 1'b0);
        run(2);
        total = 1000;
        cycle(1'b1, 1'b0, 1'b0);
        run(2);
        cycle(1'b1, 1'b0, 1'b0);
        run(3);
        cycle(1'b1, 1'b0, 1'b0);
        run(3);

        // all three buttons at once in RUN: clear wins
        cycle(1'b1, 1'b1, 1'b1);
        run(2);

        // mode in IDLE toggles; mode in RUN ignored
        cycle(1'b0, 1'b0, 1'b1);
        chk("mode_idle_toggle", 16'(bus.mode_select), 16'd1);
        run(2);
        total = 1500;
        cycle(1'b1, 1'b0, 1'b0);
        run(2);
        cycle(1'b0, 1'b0, 1'b1);
        run(3);

        // asynchronous reset mid-run
        reset = 1'b0;
        #1;
        chk("arst_state", 16'(bus.state),       16'd0);
        chk("arst_mode",  16'(bus.mode_select), 16'd0);
        chk("arst_en",    16'(bus.en),          16'd0);
        chk("arst_rst",   16'(bus.rst),         16'd0);
        chk("arst_done",  16'(bus.done),        16'd0);
        chk("arst_inc",   16'(bus.increase),    16'd0);
        chk("arst_dec",   16'(bus.decrease),    16'd0);
        model_reset();
        #2;
        reset = 1'b1;

        // random button traffic with occasional counter presets
        for (int i = 0; i < 600; i++) begin
            r  = int'($urandom_range(0, 99));
            sp = (r < 6);
            cl = (r >= 6 && r < 9);
            md = (r >= 9 && r < 14);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 4))
                    0: total = 0;
                    1: total = 1;
                    2: total = TOP_SEC;
                    3: total = TOP_SEC - 1;
                    default: total = int'($urandom_range(0, TOP_SEC));
                endcase
            end
            cycle(sp, cl, md);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
